// File: rtl/aap_fetch_unit.sv
// aap_fetch_unit: instruction fetch stage feeding the 16-bit decoder.
// Holds the word-addressed PC and reads 16-bit words over a req/ack
// handshake. A first word with bit 15 set is a 32-bit instruction whose
// second word follows. Assembled instructions are presented on fetchoutput
// with a valid/ready handshake; branch redirects arrive from downstream.
//
// Ports:
//   CLOCK_50, reset    clock and synchronous active-high reset
//   halt               blocks new fetches; an in-flight fetch completes
//   imem_req/addr      memory read request and word address (held until ack)
//   imem_ack/rdata     single-cycle read acknowledge and data
//   branch_valid/target single-cycle redirect request and target address
//   fetchoutput        {second word or 0, first word}
//   fetch_is_long      presented instruction is 32-bit
//   fetch_pc           address of the first word of the presented instruction
//   fetch_valid/ready  decoder handshake; a branch cancels a same-cycle transfer
module aap_fetch_unit #(
  parameter int unsigned         PC_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                halt,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [31:0]         fetchoutput,
  output logic                fetch_is_long,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic                fetch_valid,
  input  logic                fetch_ready
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                long_q, long_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;

  logic                req_c;
  logic                ack_c;
  logic                redirect_c;
  logic [PC_WIDTH-1:0] redirect_pc_c;
  logic [PC_WIDTH-1:0] pc_inc_c;

  // Request generation: FETCH1 starts a read only when not halted, but once a
  // read is outstanding (busy_q) it is held until ack regardless of halt.
  always_comb begin
    req_c = 1'b0;
    case (state_q)
      FETCH1:  req_c = busy_q | ~halt;
      FETCH2:  req_c = 1'b1;
      default: req_c = 1'b0;
    endcase
    req_c = req_c & ~reset;
  end

  // Acks seen without a request of ours (e.g. left over from before reset) are ignored.
  assign ack_c         = imem_ack & req_c;
  // A same-cycle branch is newer than any latched target.
  assign redirect_c    = pend_q | branch_valid;
  assign redirect_pc_c = branch_valid ? branch_target : target_q;
  assign pc_inc_c      = pc_q + PC_WIDTH'(1);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    long_d   = long_q;
    fpc_d    = fpc_q;

    case (state_q)
      FETCH1, FETCH2: begin
        if (!req_c) begin
          // Halted with nothing outstanding: redirect takes effect at once.
          if (branch_valid) begin
            pc_d = branch_target;
          end
        end else if (!ack_c) begin
          // Waiting on memory: address must stay put, so remember the branch.
          busy_d = 1'b1;
          if (branch_valid) begin
            pend_d   = 1'b1;
            target_d = branch_target;
          end
        end else begin
          busy_d = 1'b0;
          pend_d = 1'b0;
          if (redirect_c) begin
            // Returned word belongs to the wrong path; drop it.
            pc_d    = redirect_pc_c;
            state_d = FETCH1;
          end else begin
            pc_d = pc_inc_c;
            if (state_q == FETCH1) begin
              instr_d = {WORD_W'(0), imem_rdata};
              long_d  = imem_rdata[WORD_W-1];
              fpc_d   = pc_q;
              if (imem_rdata[WORD_W-1]) begin
                state_d = FETCH2;
              end else begin
                state_d = OUTPUT;
                valid_d = 1'b1;
              end
            end else begin
              instr_d[INSTR_W-1:WORD_W] = imem_rdata;
              state_d = OUTPUT;
              valid_d = 1'b1;
            end
          end
        end
      end

      OUTPUT: begin
        // A branch cancels the presented instruction even if ready is high.
        if (branch_valid) begin
          valid_d = 1'b0;
          pc_d    = branch_target;
          state_d = FETCH1;
        end else if (fetch_ready) begin
          valid_d = 1'b0;
          state_d = FETCH1;
        end
      end

      default: begin
        state_d = FETCH1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= FETCH1;
      pc_q     <= RESET_PC;
      target_q <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      long_q   <= 1'b0;
      fpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      long_q   <= long_d;
      fpc_q    <= fpc_d;
    end
  end

  assign imem_req      = req_c;
  assign imem_addr     = pc_q;
  assign fetchoutput   = instr_q;
  assign fetch_is_long = long_q;
  assign fetch_pc      = fpc_q;
  assign fetch_valid   = valid_q;

endmodule

// File: doc/aap_fetch_unit.md
Name: aap_fetch_unit

Overview:
Instruction fetch stage of the AAP pipeline, directly upstream of the 16-bit decoder. Holds the program counter and reads 16-bit words from instruction memory over a req/ack handshake. Assembles 16-bit or 32-bit instructions (first-word bit 15 set = 32-bit) and presents them to the decoder on fetchoutput with a valid/ready handshake. Takes branch redirects from downstream.

Parameters:
PC_WIDTH, 24, width of word-addressed program counter
RESET_PC, 0, PC value loaded on reset

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
halt  input  1  when high, no new fetch is started; an in-flight fetch completes
imem_req  output  1  memory read request, held until ack
imem_addr  output  PC_WIDTH  word address, stable while imem_req high
imem_ack  input  1  single-cycle; imem_rdata valid this cycle; may be high in the same cycle req first rises
imem_rdata  input  16  read data
branch_valid  input  1  single-cycle redirect request
branch_target  input  PC_WIDTH  redirect word address
fetchoutput  output  32  [15:0] first word; [31:16] second word (0 for 16-bit instrs)
fetch_is_long  output  1  1 = 32-bit instruction
fetch_pc  output  PC_WIDTH  address of first word of presented instruction
fetch_valid  output  1  instruction on fetchoutput is valid
fetch_ready  input  1  decoder accepts; transfer = fetch_valid & fetch_ready & ~branch_valid

Behaviour:
- Reset: pc=RESET_PC, state=FETCH1, imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetchoutput=0, fetch_is_long=0, fetch_pc=0, redirect_pending=0. Reset overrides all inputs, including mid-request; any outstanding ack after reset is ignored until the first new request.
- States: FETCH1, FETCH2, OUTPUT.
- FETCH1: imem_req=~halt, imem_addr=pc. On ack: word0<=rdata, pc<=pc+1. If rdata[15]=1, go to FETCH2; otherwise go to OUTPUT with fetch_valid=1.
- FETCH2: imem_req=1, imem_addr=pc. On ack: word1<=rdata, pc<=pc+1, go to OUTPUT with fetch_valid=1.
- OUTPUT: fetchoutput, fetch_is_long and fetch_pc are stable while fetch_valid=1 and no transfer occurs. On transfer: fetch_valid<=0, go to FETCH1. The next request starts on the following cycle.
- PC arithmetic: modulo 2^PC_WIDTH. A 32-bit instruction at max address wraps its second word to address 0.
- Branch in FETCH1/FETCH2 with no ack that cycle: set redirect_pending, latch target, keep imem_req and imem_addr stable until ack. On ack: discard data, pc<=target, clear pending, go to FETCH1.
- Branch in the same cycle as ack: data discarded, pc<=target, go to FETCH1.
- Branch in FETCH1 with halt=1 (no request outstanding): pc<=target immediately.
- Branch in OUTPUT: fetch_valid<=0, pc<=target, go to FETCH1. A same-cycle fetch_ready is not a transfer.
- A later branch while redirect_pending=1 overwrites the latched target.
- Latency, zero-wait memory: 16-bit instr valid 1 cycle after first req cycle; 32-bit instr valid 2 cycles after. Peak throughput is one 16-bit instruction per 2 cycles.
- imem_req never drops without an ack except on reset.

Test Plan:
- Reset then zero-wait memory holding 0x1234 at 0 -> imem_req=1 addr=0 in cycle 1; cycle 2 fetch_valid=1, fetchoutput=0x00001234, fetch_is_long=0, fetch_pc=0.
- Words 0x8001 and 0xABCD at addresses 4,5, pc=4 -> fetchoutput=0xABCD8001, fetch_is_long=1, fetch_pc=4, next request addr=6.
- fetch_ready=0 for 5 cycles in OUTPUT -> outputs stable, no imem_req; ready=1 -> valid drops next cycle, request to next addr.
- Memory ack delayed 3 cycles, branch_valid (target 0x40) in wait cycle 1 -> addr held until ack, data discarded, fetch_valid stays 0, next request addr=0x40.
- branch_valid with fetch_valid=1 and fetch_ready=1 same cycle -> no transfer counted, fetch_valid=0 next cycle, request addr=branch_target.
- pc=0xFFFFFF with 32-bit instr (PC_WIDTH=24) -> second request addr=0x000000, fetch_pc=0xFFFFFF, following request addr=0x000001.
